// File: rtl/getwork_serial_rx.sv
// getwork_serial_rx
// UART receiver (8N1, LSB first, oversampled by DIV = clk / baud) that
// assembles NUM_BYTES consecutive bytes into one work word. The word is
// published on data only once the whole frame has arrived. A bad stop bit,
// or an idle gap of TIMEOUT_BITS bit-times in the middle of a frame, drops
// the partial frame.
//
// Ports:
//   clk           - sole clock, rising edge
//   reset_n       - asynchronous active-low reset
//   RxD           - asynchronous serial input, idle high
//   data          - last complete frame; first byte in the top 8 bits
//   rx_done       - one-cycle pulse when data has just been updated
//   framing_error - one-cycle pulse on a bad stop bit
module getwork_serial_rx #(
    parameter int unsigned comm_clk_frequency = 100_000_000,
    parameter int unsigned baud_rate          = 115_200,
    parameter int unsigned NUM_BYTES          = 84,
    parameter int unsigned TIMEOUT_BITS       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   RxD,
    output logic [8*NUM_BYTES-1:0] data,
    output logic                   rx_done,
    output logic                   framing_error
);

    localparam int unsigned DIV       = comm_clk_frequency / baud_rate;
    localparam int unsigned HALF      = DIV / 2;
    localparam int unsigned TW        = $clog2(DIV);
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * DIV;
    localparam int unsigned IW        = $clog2(TO_CYCLES);
    localparam int unsigned CW        = $clog2(NUM_BYTES);
    localparam int unsigned DW        = 8 * NUM_BYTES;

    localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [IW-1:0] TO_LAST   = IW'(TO_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            sync1;
    logic            sync2;
    logic            prev;
    logic            start_edge;

    logic [TW-1:0]   timer;
    logic [2:0]      bit_index;
    logic [7:0]      shift_byte;
    logic [DW-1:0]   staging;
    logic [DW-1:0]   staging_next;
    logic [CW-1:0]   byte_count;
    logic [IW-1:0]   idle_cnt;

    logic            half_end;
    logic            bit_end;
    logic            stop_end;

    assign start_edge   = prev & ~sync2;
    assign half_end     = (timer == HALF_LAST);
    assign bit_end      = (timer == BIT_LAST);
    assign stop_end     = (state == STOP) && bit_end;
    assign staging_next = {staging[DW-9:0], shift_byte};

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= RxD;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again mid-bit was a glitch
                if (half_end) begin
                    state_next = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_index == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer         <= '0;
            bit_index     <= '0;
            shift_byte    <= '0;
            staging       <= '0;
            byte_count    <= '0;
            idle_cnt      <= '0;
            data          <= '0;
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_done       <= 1'b0;
            framing_error <= 1'b0;

            // Timer restarts on every state change and on every data bit
            if ((state == IDLE) || (state_next != state) ||
                ((state == DATA) && bit_end)) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if ((state == START) && half_end) begin
                bit_index <= '0;
            end

            if ((state == DATA) && bit_end) begin
                shift_byte[bit_index] <= sync2;
                bit_index             <= bit_index + 3'd1;
            end

            if (stop_end) begin
                if (sync2) begin
                    staging <= staging_next;
                    if (byte_count == CNT_LAST) begin
                        byte_count <= '0;
                        data       <= staging_next;
                        rx_done    <= 1'b1;
                    end else begin
                        byte_count <= byte_count + CW'(1);
                    end
                end else begin
                    byte_count    <= '0;
                    framing_error <= 1'b1;
                end
            end

            // Mid-frame idle timeout; a start edge in the firing cycle wins.
            // Staging is left alone since the next full frame overwrites it.
            if ((state == IDLE) && (byte_count != '0) && !start_edge) begin
                if (idle_cnt == TO_LAST) begin
                    idle_cnt   <= '0;
                    byte_count <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_getwork_serial_rx.sv
// Self-checking bench for getwork_serial_rx at DIV = 8. Random frames are
// driven serially; a byte-level model predicts published words and pulses.
module tb_getwork_serial_rx;

    localparam int unsigned NB  = 84;
    localparam int unsigned DW  = 8 * NB;
    localparam int unsigned DIV = 8;
    localparam int unsigned TOB = 32;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          RxD     = 1'b1;
    logic [DW-1:0] data;
    logic          rx_done;
    logic          framing_error;

    getwork_serial_rx #(
        .comm_clk_frequency(1_000_000),
        .baud_rate         (125_000),
        .NUM_BYTES         (NB),
        .TIMEOUT_BITS      (TOB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RxD          (RxD),
        .data         (data),
        .rx_done      (rx_done),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    int unsigned   rx_cnt  = 0;
    int unsigned   fe_cnt  = 0;
    int unsigned   exp_rx  = 0;
    int unsigned   exp_fe  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_data = '0;
    byte unsigned  pend[$];
    byte unsigned  fr[NB];

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: bytes accumulate; a full set publishes a word, a bad stop or a
    // long idle gap drops what has accumulated.
    task automatic model_byte(input byte unsigned b, input bit good);
        logic [DW-1:0] v;
        if (good) begin
            pend.push_back(b);
            if (pend.size() == NB) begin
                v = '0;
                for (int i = 0; i < NB; i++) begin
                    v[DW-1-8*i -: 8] = pend[i];
                end
                exp_q.push_back(v);
                model_data = v;
                exp_rx++;
                pend.delete();
            end
        end else begin
            pend.delete();
            exp_fe++;
        end
    endtask

    task automatic idle_bits(input int unsigned n);
        RxD = 1'b1;
        repeat (n * DIV) @(negedge clk);
        if (n >= TOB) pend.delete();
    endtask

    // Model is updated as the stop bit begins, ahead of the DUT's pulse.
    task automatic send_byte(input byte unsigned b, input bit stop);
        RxD = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (DIV) @(negedge clk);
        end
        RxD = stop;
        model_byte(b, stop);
        repeat (DIV) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NB; i++) fr[i] = byte'($urandom_range(0, 255));
    endtask

    task automatic send_range(input int unsigned first, input int unsigned count);
        for (int unsigned i = first; i < first + count; i++) send_byte(fr[i], 1'b1);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_rx"}, DW'(rx_cnt), DW'(exp_rx));
        check_eq({tag, "_fe"}, DW'(fe_cnt), DW'(exp_fe));
        check_eq({tag, "_data"}, data, model_data);
    endtask

    always @(negedge clk) begin
        if (rx_done) begin
            rx_cnt++;
            if (exp_q.size() != 0) check_eq("rx_data", data, exp_q.pop_front());
        end
        if (framing_error) fe_cnt++;
        if (rx_done || framing_error)
            check_eq("pulse_excl", DW'(rx_done & framing_error), '0);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_data", data, '0);
        check_eq("reset_rx_done", DW'(rx_done), '0);
        check_eq("reset_fe", DW'(framing_error), '0);
        reset_n = 1'b1;
        idle_bits(2);

        // Single frame with a fixed header and tail
        rand_frame();
        fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h07; fr[3] = 8'hff;
        fr[4] = 8'h00; fr[5] = 8'h00; fr[6] = 8'h31; fr[7] = 8'h8e;
        fr[80] = 8'h01; fr[81] = 8'h00; fr[82] = 8'h00; fr[83] = 8'h00;
        send_range(0, NB - 1);
        check_eq("t1_partial_hidden", data, '0);
        send_range(NB - 1, 1);
        idle_bits(2);
        check_counts("t1");

        // Two back-to-back frames
        rand_frame();
        send_range(0, NB);
        rand_frame();
        send_range(0, NB);
        idle_bits(2);
        check_counts("t2");

        // Partial frame dropped by an idle timeout
        rand_frame();
        send_range(0, 40);
        idle_bits(40);
        check_counts("t3_partial");
        rand_frame();
        send_range(0, NB);
        idle_bits(2);
        check_counts("t3");

        // Bad stop bit on the 10th byte, then a clean frame
        rand_frame();
        send_range(0, 9);
        send_byte(fr[9], 1'b0);
        idle_bits(2);
        check_counts("t4_err");
        rand_frame();
        send_range(0, NB);
        idle_bits(2);
        check_counts("t4");

        // Short low glitch inside a frame must not disturb the byte count
        rand_frame();
        send_range(0, 10);
        RxD = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(2);
        check_counts("t5_glitch");
        send_range(10, NB - 10);
        idle_bits(2);
        check_counts("t5");

        // Asynchronous reset in the middle of byte 51
        rand_frame();
        send_range(0, 50);
        RxD = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_data", data, '0);
        check_eq("t6_rst_rx_done", DW'(rx_done), '0);
        check_eq("t6_rst_fe", DW'(framing_error), '0);
        pend.delete();
        model_data = '0;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        idle_bits(2);
        rand_frame();
        send_range(0, NB);
        idle_bits(2);
        check_counts("t6");

        // Random frame with short random inter-byte gaps
        rand_frame();
        for (int i = 0; i < NB; i++) begin
            send_byte(fr[i], 1'b1);
            idle_bits($urandom_range(0, 3));
        end
        idle_bits(2);
        check_counts("t7");
        check_eq("queue_drained", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
